uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive half of the team's serial link, paired with the existing transmitter.
- Frame format: 8N1, LSB first. Idle line is high. Default timing is 2604 clk per bit (0xA2C, 19200 baud at 50 MHz).
- Over-samples the asynchronous rx pin and captures one byte per frame.
- Presents the byte with a sticky rdy flag, cleared by the consumer (command/host logic).

Parameters:
- BAUD_CNT, 2604: clocks per bit. Must be >= 8. Counter width is 12 bits, so BAUD_CNT must be <= 4095.
- HALF_CNT, BAUD_CNT/2 (integer division): delay from detected start edge to the mid-start-bit sample.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy.
- rx_data  output  8  last received byte.
- rdy  output  1  byte available, sticky.
- frm_err  output  1  stop-bit error flag; tied 0 unless UART_RX_FRM_ERR_EN is defined.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - rx_data = 8'h00, rdy = 0, frm_err = 0.
  - Both rx synchroniser flops = 1 (line idle).
  - State = IDLE, baud counter = 0, bit counter = 0.
- Synchroniser: two flops on rx. A third flop holds the previous synced value for edge detection. Only the synced signal is used internally.
- Baud counter: 12-bit down-counter.
  - Loaded with HALF_CNT on start detection and with BAUD_CNT-1 after every sample.
  - A sample strobe fires when the counter reaches 0.
- Bit counter: 4 bits. Cleared in IDLE; increments on each sample strobe. The frame is complete after 10 samples (start, d0..d7, stop).
- State machine (IDLE, RX):
  - IDLE -> RX on a falling edge of the synced rx (prev=1, now=0). The same cycle loads HALF_CNT and clears the bit counter.
  - RX, first sample (start bit):
    - If sampled 1 (glitch), abort to IDLE. No rdy, rx_data unchanged.
  - RX, samples 2-9: shift the sampled bit into bit 7 of an 8-bit shift register, shifting right, so d0 ends up in bit 0.
  - RX, sample 10 (stop bit): rx_data <= shift register, rdy <= 1, state -> IDLE, all in one clock edge.
- Latency:
  - rx_data and rdy are valid 3 clocks (sync + edge detect) plus HALF_CNT + 9*BAUD_CNT + 1 clocks after the rx pin falls.
  - Bench tolerance is ±2 clk.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving any time after that is caught. There is no inter-frame gap requirement beyond the stop bit.
- rdy rules:
  - Set at frame completion.
  - Cleared by clr_rdy, or by detection of the next start edge.
  - If set and clear coincide in the same cycle, set wins.
  - clr_rdy while rdy=0 is ignored.
- rx_data holds its value until the next completed frame; it is not cleared by clr_rdy.
- A byte completing while rdy=1 overwrites rx_data. There is no overrun flag.
- Stop bit sampled 0 without the feature: the byte is delivered normally.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded.
- rx held low continuously (break): one frame with data 0x00 and a bad stop bit is received. There is then no new start until rx returns high and falls again.

Optional Feature:
- Macro: UART_RX_FRM_ERR_EN.
- Defined:
  - frm_err is set together with rdy when the stop sample is 0.
  - It is cleared when rdy clears, and is set to 0 on a good-stop frame completion.
  - The byte is still delivered.
- Undefined: frm_err is constant 0, and no stop-bit check logic is built.

Test Plan:
- Reset with rx=1, then idle 10000 clk -> rdy=0, rx_data=0x00, frm_err=0, state stays IDLE.
- Send 0xA5 at BAUD_CNT=2604 -> rx_data=0xA5 and rdy=1 within ±2 clk of the computed latency. Pulse clr_rdy -> rdy=0 next cycle, rx_data stays 0xA5.
- Back-to-back: BAUD_CNT=16, frames 0x00, 0xFF, 0x3C with no idle gap. Read each byte between rdy rise and the next start edge -> 0x00, 0xFF, 0x3C. rdy drops at each new start edge.
- Glitch: rx low for 3 clk, then high (BAUD_CNT=16) -> no rdy, rx_data unchanged. A following 0x5A frame is received correctly.
- Reset mid-frame: assert rst_n=0 during bit 4 of 0x81, release, then send 0x7E -> rx_data=0x7E. There is no rdy for the aborted frame.
- With UART_RX_FRM_ERR_EN: send 0x42 with stop bit 0 -> rdy=1, frm_err=1, rx_data=0x42. Then clr_rdy -> both 0. A good 0x42 frame -> frm_err=0.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Bus bundle between the UART receiver and its consumer.
//                rx       - serial line into the receiver (idles high)
//                clr_rdy  - consumer acknowledge, clears rdy
//                rx_data  - last received byte
//                rdy      - sticky byte-available flag
//                frm_err  - stop-bit error flag
//                master   : consumer / line side
//                slave    : receiver side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
   logic       rx;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;

   modport master (
      output rx,
      output clr_rdy,
      input  rx_data,
      input  rdy,
      input  frm_err
   );

   modport slave (
      input  rx,
      input  clr_rdy,
      output rx_data,
      output rdy,
      output frm_err
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, idle-high line. Synchronises
//                the asynchronous rx pin, detects the start edge, samples each
//                bit at its centre and presents the byte with a sticky rdy.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                bus      - uart_rx_if.slave (rx, clr_rdy in;
//                           rx_data, rdy, frm_err out)
//  Options     : UART_RX_FRM_ERR_EN - when defined, frm_err flags a frame
//                whose stop bit sampled 0; otherwise frm_err is tied 0.
//  Parameters  : BAUD_CNT - clocks per bit (8..4095)
//                HALF_CNT - start edge to mid-start-bit delay
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int BAUD_CNT = 2604,
   parameter int HALF_CNT = BAUD_CNT / 2
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave bus
);

   localparam logic [11:0] c_HALF    = 12'(HALF_CNT);
   localparam logic [11:0] c_BAUD_M1 = 12'(BAUD_CNT - 1);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RX   = 1'b1;

   // Synchroniser and edge-detect flops
   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   logic [0:0]  state_q, state_d;
   logic [11:0] baud_q,  baud_d;
   logic [3:0]  bit_q,   bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q,  data_d;
   logic        rdy_q,   rdy_d;

   logic w_rx_s;
   logic w_start;
   logic w_strobe;
   logic w_abort;
   logic w_done;

   assign w_rx_s   = sync2_q;
   assign w_start  = (state_q == c_IDLE) && prev_q && !sync2_q;
   assign w_strobe = (state_q == c_RX) && (baud_q == 12'd0);
   // A start bit that reads high at its centre was a glitch
   assign w_abort  = w_strobe && (bit_q == 4'd0) && w_rx_s;
   // Tenth sample is the stop bit; the frame completes here
   assign w_done   = w_strobe && (bit_q == 4'd9);

   // ------------------------------------------------------------------
   // State / data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= c_IDLE;
         baud_q  <= 12'd0;
         bit_q   <= 4'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         rdy_q   <= 1'b0;
      end else begin
         sync1_q <= bus.rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (w_start) state_d = c_RX;
         c_RX:    if (w_abort || w_done) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Counters, shift register and output flags
   // ------------------------------------------------------------------
   always_comb begin
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      rdy_d   = rdy_q;

      if (state_q == c_IDLE) begin
         bit_d = 4'd0;
         if (w_start) baud_d = c_HALF;
      end else if (w_strobe) begin
         baud_d = c_BAUD_M1;
         bit_d  = bit_q + 4'd1;
         // Samples 2..9 carry d0..d7; shifting right leaves d0 in bit 0
         if ((bit_q != 4'd0) && (bit_q != 4'd9))
            shift_d = {w_rx_s, shift_q[7:1]};
      end else begin
         baud_d = baud_q - 12'd1;
      end

      // Clear first so a coincident frame completion wins
      if (w_start || bus.clr_rdy) rdy_d = 1'b0;
      if (w_done) begin
         rdy_d  = 1'b1;
         data_d = shift_q;
      end
   end

`ifdef UART_RX_FRM_ERR_EN
   logic frm_err_q, frm_err_d;

   always_comb begin
      frm_err_d = frm_err_q;
      if (w_start || bus.clr_rdy) frm_err_d = 1'b0;
      if (w_done) frm_err_d = !w_rx_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frm_err_q <= 1'b0;
      else        frm_err_q <= frm_err_d;
   end

   assign bus.frm_err = frm_err_q;
`else
   assign bus.frm_err = 1'b0;
`endif

   assign bus.rx_data = data_q;
   assign bus.rdy     = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. Instance A runs at
//                2604 clk/bit for the latency test, instance B at 16 clk/bit
//                for back-to-back, glitch, stop-error and reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   uart_rx_if bus_a ();
   uart_rx_if bus_b ();

   uart_rx #(.BAUD_CNT(2604)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   uart_rx #(.BAUD_CNT(16))   u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One 16-clk/bit frame on bus B, starting at a falling clock edge.
   // Checks rdy low shortly after the start edge (optional) and the
   // delivered byte near the end of the stop bit.
   task automatic send_b(input logic [7:0] d, input logic stop_bit,
                         input logic [7:0] exp_data, input logic chk_drop,
                         input string tag);
      logic [9:0] fr;
      fr = {stop_bit, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bus_b.rx = fr[i];
         for (int c = 0; c < 16; c++) begin
            if (chk_drop && i == 0 && c == 5)
               chk({31'd0, bus_b.rdy}, 32'd0, {tag, "_rdy_drop"});
            if (i == 9 && c == 14) begin
               chk({31'd0, bus_b.rdy}, 32'd1, {tag, "_rdy"});
               chk({24'd0, bus_b.rx_data}, {24'd0, exp_data}, {tag, "_data"});
            end
            @(negedge clk);
         end
      end
      bus_b.rx = 1'b1;
   endtask

   task automatic pulse_clr_b();
      bus_b.clr_rdy = 1'b1;
      @(negedge clk);
      bus_b.clr_rdy = 1'b0;
   endtask

   initial begin
      logic [7:0] a_byte;
      logic [9:0] fr;
      int         n;
      logic       exp_fe;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_a.rx = 1'b1; bus_a.clr_rdy = 1'b0;
      bus_b.rx = 1'b1; bus_b.clr_rdy = 1'b0;
      repeat (5) @(negedge clk);

      // Reset values
      chk({31'd0, bus_a.rdy},       32'd0, "rst_rdy");
      chk({24'd0, bus_a.rx_data},   32'd0, "rst_data");
      chk({31'd0, bus_a.frm_err},   32'd0, "rst_frm_err");
      rst_n = 1'b1;

      // Idle line for 10000 clocks: nothing received
      repeat (10000) @(negedge clk);
      chk({31'd0, bus_a.rdy},       32'd0, "idle_rdy");
      chk({24'd0, bus_a.rx_data},   32'd0, "idle_data");
      chk({31'd0, bus_a.frm_err},   32'd0, "idle_frm_err");
      chk({31'd0, bus_b.rdy},       32'd0, "idle_rdy_b");

      // 0xA5 at 2604 clk/bit; expected rdy at 3+1302+9*2604+1 = 24742
      a_byte = 8'hA5;
      fr = {1'b1, a_byte, 1'b0};
      for (int i = 0; i < 9; i++) begin
         bus_a.rx = fr[i];
         repeat (2604) @(negedge clk);
      end
      bus_a.rx = 1'b1;
      n = 23436;
      while (bus_a.rdy !== 1'b1 && n < 27000) begin
         @(negedge clk);
         n++;
      end
      chk({31'd0, (n >= 24740 && n <= 24744)}, 32'd1, "a_latency");
      chk({24'd0, bus_a.rx_data}, 32'h0000_00A5, "a_data");
      repeat (26040 - n) @(negedge clk);
      bus_a.clr_rdy = 1'b1;
      @(negedge clk);
      bus_a.clr_rdy = 1'b0;
      chk({31'd0, bus_a.rdy},     32'd0,          "a_clr_rdy");
      chk({24'd0, bus_a.rx_data}, 32'h0000_00A5,  "a_data_hold");

      // Back-to-back frames, no idle gap
      send_b(8'h00, 1'b1, 8'h00, 1'b0, "b2b0");
      send_b(8'hFF, 1'b1, 8'hFF, 1'b1, "b2b1");
      send_b(8'h3C, 1'b1, 8'h3C, 1'b1, "b2b2");
      repeat (10) @(negedge clk);
      pulse_clr_b();
      chk({31'd0, bus_b.rdy}, 32'd0, "b_clr_rdy");

      // Glitch: 3 clk low pulse must be rejected
      bus_b.rx = 1'b0;
      repeat (3) @(negedge clk);
      bus_b.rx = 1'b1;
      repeat (40) @(negedge clk);
      chk({31'd0, bus_b.rdy},     32'd0,         "glitch_rdy");
      chk({24'd0, bus_b.rx_data}, 32'h0000_003C, "glitch_data");
      send_b(8'h5A, 1'b1, 8'h5A, 1'b0, "post_glitch");
      repeat (10) @(negedge clk);

      // Bad stop bit: byte still delivered; frm_err only with the option
`ifdef UART_RX_FRM_ERR_EN
      exp_fe = 1'b1;
`else
      exp_fe = 1'b0;
`endif
      send_b(8'h42, 1'b0, 8'h42, 1'b1, "bad_stop");
      repeat (20) @(negedge clk);
      chk({31'd0, bus_b.frm_err}, {31'd0, exp_fe}, "bad_stop_frm_err");
      chk({31'd0, bus_b.rdy},     32'd1,           "bad_stop_rdy_held");
      pulse_clr_b();
      chk({31'd0, bus_b.rdy},     32'd0, "bad_stop_clr_rdy");
      chk({31'd0, bus_b.frm_err}, 32'd0, "bad_stop_clr_frm_err");
      send_b(8'h42, 1'b1, 8'h42, 1'b0, "good_stop");
      repeat (5) @(negedge clk);
      chk({31'd0, bus_b.frm_err}, 32'd0, "good_stop_frm_err");

      // Reset during bit 4 of 0x81, then a clean 0x7E
      fr = {1'b1, 8'h81, 1'b0};
      for (int i = 0; i < 5; i++) begin
         bus_b.rx = fr[i];
         repeat (16) @(negedge clk);
      end
      bus_b.rx = fr[5];
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk({31'd0, bus_b.rdy},     32'd0, "midrst_rdy");
      chk({24'd0, bus_b.rx_data}, 32'd0, "midrst_data");
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      bus_b.rx = 1'b1;
      repeat (200) @(negedge clk);
      chk({31'd0, bus_b.rdy},     32'd0, "midrst_no_rdy");
      send_b(8'h7E, 1'b1, 8'h7E, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
